keccak_absorb_stream: RTL and testbench
=======================================

# keccak_absorb_stream

Sequential, parametrised absorb engine for the Keccak sponge. It accepts a byte-granular message stream over a valid/ready handshake and XORs each beat into the externally held state at any byte offset. A straddling beat is held internally and absorbed into the next block, so the upstream never sees a carry. The engine requests permutations from the permutation core and applies pad10*1 with the domain suffix on the last beat. It sits between the input FIFO and the state register / permutation core.

## Interface
- DWIDTH, 256: stream data width in bits; multiple of 64, 64..512.
- KEEP_W, DWIDTH/8: byte-enable width.
- clk  in  1  clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin a message; sampled only in IDLE.
- rate_i  in  RATE_WIDTH  rate in bits (576/832/1088/1152/1344); latched on start_i.
- suffix_i  in  8  domain suffix byte (0x06 SHA3, 0x1F SHAKE); latched on start_i.
- s_valid_i  in  1  beat valid.
- s_ready_o  out  1  beat ready.
- s_data_i  in  DWIDTH  beat data, byte 0 in bits [7:0].
- s_keep_i  in  KEEP_W  byte enables; contiguous from bit 0; all-ones except on the last beat, which may be 0.
- s_last_i  in  1  final beat of message.
- state_i  in  1600  current state (lane [x][y] packing per keccak_pkg).
- state_o  out  1600  state with injected bytes.
- state_we_o  out  1  write strobe for state_o.
- perm_start_o  out  1  one-cycle permutation request.
- perm_done_i  in  1  one-cycle permutation completion.
- busy_o  out  1  high in every state except IDLE.
- absorb_done_o  out  1  one-cycle pulse when the final padded block has been permuted.

## Operation
- **FSM states:** IDLE, ABSORB, PERMUTE, CARRY, PAD, FINAL.
- **IDLE**
  - On start_i: latch rate and suffix, clear the byte offset, clear the last and carry flags, then go to ABSORB.
- **ABSORB**
  - s_ready_o is high.
  - On handshake: n = popcount(keep). The bytes XOR into state at byte offset off, clipped at rate_bytes, and state_we_o asserts.
  - off+n < R (R = rate_bytes):
    - off += n.
    - If last, go to PAD; otherwise stay.
  - off+n == R: off = 0, pulse perm_start, go to PERMUTE. The last flag is recorded.
  - off+n > R:
    - Store data>>(8·(R−off)) and keep>>(R−off) in the carry register, and set the carry flag.
    - off = 0, pulse perm_start, go to PERMUTE.
- **PERMUTE**
  - s_ready_o is low.
  - On perm_done_i: carry set goes to CARRY; otherwise last set goes to PAD; otherwise ABSORB.
- **CARRY**
  - XOR the carry bytes at offset 0, set off = carry count, clear the carry flag.
  - Go to PAD if last, otherwise ABSORB.
  - The carry count is at most 63 bytes, which is below the minimum rate of 72 bytes, so a carry never fills a block.
- **PAD**
  - In one write: byte[off] ^= suffix and byte[R−1] ^= 0x80. When off == R−1 the combined value is applied, giving 0x86 or 0x9F.
  - Pulse perm_start and go to FINAL.
- **FINAL**
  - On perm_done_i: pulse absorb_done_o and go to IDLE.
- start_i is ignored outside IDLE. perm_done_i is ignored outside PERMUTE and FINAL.
- **Width rules**
  - off is BYTE_ABSORB_WIDTH wide.
  - The comparison off+n is evaluated one bit wider.
  - The shift amount is computed in bytes and saturates at KEEP_W.

## Timing
- **Reset values:** all outputs are 0, the state is IDLE, and the offset, carry and last registers are cleared.
- rst mid-operation: return to IDLE next cycle with no further state_we_o or perm_start_o. The permutation core is reset by the same rst.
- state_o and state_we_o are combinational from state_i and the current beat or carry, and are written in the handshake cycle.
- perm_start_o is registered: it pulses in the cycle after the write that fills a block or applies padding.
- s_ready_o is registered from the FSM state. It is low in CARRY, so upstream stalls exactly one cycle after a straddle's permutation.
- Beats are never dropped or duplicated under arbitrary s_valid_i gaps or perm_done_i delay.

## Structure
- **keccak_pkg additions:**
  - absorb_state_e enum.
  - SUFFIX_SHA3 = 8'h06, SUFFIX_SHAKE = 8'h1F, PAD_LAST = 8'h80.
  - MIN_RATE_BYTES = 72.
- **Sub-module keccak_byte_inject** (combinational):
  - Inputs: state, DWIDTH chunk, keep, byte offset, rate.
  - Function: XORs the chunk byte-wise into the state, clipped at rate.
  - Instantiated once; its inputs are muxed between beat, carry and pad bytes.

## Test plan
- **SHA3-256 empty message** (rate 1088, suffix 0x06; one beat, last=1, keep=0):
  - byte0 ^= 0x06, byte135 ^= 0x80.
  - One perm_start, then absorb_done.
- **Straddle** (rate 1088, DWIDTH 256; five full beats, no last):
  - Beat 5 writes bytes 128..135 and pulses perm_start.
  - s_ready stays low until perm_done plus one cycle.
  - The carry's 24 bytes land at bytes 0..23 and off = 24.
- **Exact fill then last** (beats of 32,32,32,32 bytes, then keep=0xFF with last):
  - Two permutations.
  - The second block holds byte0 = 0x06 and byte135 = 0x80.
- **Overlapping pad:**
  - 135 bytes with suffix 0x06 gives byte135 = 0x86.
  - Repeated with suffix 0x1F, byte135 = 0x9F.
- **Back-pressure:** perm_done delayed 24 cycles with s_valid held high. No beat is consumed during PERMUTE, and the final state matches the golden sponge model.
- **Reset during PERMUTE:** outputs are 0 on the next cycle, and a fresh start_i then produces a correct digest.

Source files
------------

// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared types and constants for the Keccak absorb path
package keccak_pkg;

   localparam int STATE_W           = 1600;
   localparam int STATE_BYTES       = 200;
   localparam int RATE_WIDTH        = 11;
   localparam int BYTE_ABSORB_WIDTH = 8;
   localparam int MIN_RATE_BYTES    = 72;

   localparam logic [7:0] SUFFIX_SHA3  = 8'h06;
   localparam logic [7:0] SUFFIX_SHAKE = 8'h1F;
   localparam logic [7:0] PAD_LAST     = 8'h80;

   typedef enum logic [2:0] {
      IDLE,
      ABSORB,
      PERMUTE,
      CARRY,
      PAD,
      FINAL
   } absorb_state_e;

endpackage

// File: rtl/keccak_byte_inject.sv
// rtl/keccak_byte_inject.sv - XORs a byte-enabled chunk into the state at a byte offset, clipped at the rate
module keccak_byte_inject
   import keccak_pkg::*;
#(
   parameter int DWIDTH = 256,
   parameter int KEEP_W = DWIDTH / 8
) (
   input  logic [STATE_W-1:0]           state,
   input  logic [DWIDTH-1:0]            chunk,
   input  logic [KEEP_W-1:0]            keep,
   input  logic [BYTE_ABSORB_WIDTH-1:0] offset,
   input  logic [BYTE_ABSORB_WIDTH-1:0] rate_bytes,
   output logic [STATE_W-1:0]           result
);

   logic [STATE_W-1:0] byte_mask;
   logic [STATE_W-1:0] rate_mask;
   logic [STATE_W-1:0] data_ext;
   logic [STATE_W-1:0] mask_ext;

   always_comb begin
      byte_mask = '0;
      for (int b = 0; b < KEEP_W; b++) begin
         byte_mask[8*b +: 8] = {8{keep[b]}};
      end
      rate_mask = '0;
      for (int i = 0; i < STATE_BYTES; i++) begin
         rate_mask[8*i +: 8] = {8{BYTE_ABSORB_WIDTH'(i) < rate_bytes}};
      end
   end

   assign data_ext = STATE_W'(chunk) << {offset, 3'b000};
   assign mask_ext = byte_mask << {offset, 3'b000};
   assign result   = state ^ (data_ext & mask_ext & rate_mask);

endmodule

// File: rtl/keccak_absorb_stream.sv
// rtl/keccak_absorb_stream.sv - byte-granular stream absorb engine with carry of straddling beats and pad10*1
module keccak_absorb_stream
   import keccak_pkg::*;
#(
   parameter int DWIDTH = 256,
   parameter int KEEP_W = DWIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic [RATE_WIDTH-1:0] rate_i,
   input  logic [7:0]            suffix_i,
   input  logic                  s_valid_i,
   output logic                  s_ready_o,
   input  logic [DWIDTH-1:0]     s_data_i,
   input  logic [KEEP_W-1:0]     s_keep_i,
   input  logic                  s_last_i,
   input  logic [STATE_W-1:0]    state_i,
   output logic [STATE_W-1:0]    state_o,
   output logic                  state_we_o,
   output logic                  perm_start_o,
   input  logic                  perm_done_i,
   output logic                  busy_o,
   output logic                  absorb_done_o
);

   localparam int OFF_W = BYTE_ABSORB_WIDTH;
   localparam int N_W   = $clog2(KEEP_W + 1);

   absorb_state_e        state_q;
   logic [RATE_WIDTH-1:0] rate_q;
   logic [7:0]           suffix_q;
   logic [OFF_W-1:0]     off_q;
   logic                 last_q;
   logic                 carry_q;
   logic [DWIDTH-1:0]    carry_data_q;
   logic [KEEP_W-1:0]    carry_keep_q;

   logic [OFF_W-1:0]     rate_bytes;
   logic                 hs;
   logic [N_W-1:0]       beat_n;
   logic [N_W-1:0]       carry_n;
   logic [OFF_W:0]       sum;
   logic [OFF_W:0]       rate_ext;
   logic [OFF_W-1:0]     room;
   logic [OFF_W-1:0]     shift_sat;
   logic [DWIDTH-1:0]    inj_chunk;
   logic [KEEP_W-1:0]    inj_keep;
   logic [OFF_W-1:0]     inj_off;
   logic [STATE_W-1:0]   inj_result;
   logic [STATE_W-1:0]   pad_last;

   assign rate_bytes = OFF_W'(rate_q >> 3);
   assign hs         = (state_q == ABSORB) && s_valid_i && s_ready_o;
   assign beat_n     = N_W'($countones(s_keep_i));
   assign carry_n    = N_W'($countones(carry_keep_q));
   assign sum        = {1'b0, off_q} + (OFF_W+1)'(beat_n);
   assign rate_ext   = {1'b0, rate_bytes};
   assign room       = rate_bytes - off_q;
   // Bytes of the beat that fit in this block; beyond KEEP_W the whole beat fits.
   assign shift_sat  = (room > OFF_W'(KEEP_W)) ? OFF_W'(KEEP_W) : room;

   always_comb begin
      inj_chunk = s_data_i;
      inj_keep  = s_keep_i;
      inj_off   = off_q;
      case (state_q)
         CARRY: begin
            inj_chunk = carry_data_q;
            inj_keep  = carry_keep_q;
            inj_off   = '0;
         end
         PAD: begin
            inj_chunk = DWIDTH'(suffix_q);
            inj_keep  = KEEP_W'(1);
         end
         default: ;
      endcase
   end

   keccak_byte_inject #(
      .DWIDTH (DWIDTH),
      .KEEP_W (KEEP_W)
   ) u_inject (
      .state      (state_i),
      .chunk      (inj_chunk),
      .keep       (inj_keep),
      .offset     (inj_off),
      .rate_bytes (rate_bytes),
      .result     (inj_result)
   );

   // Second half of the pad lands on the last rate byte and stacks on the suffix when off == R-1.
   assign pad_last   = (state_q == PAD) ?
                       (STATE_W'(PAD_LAST) << {rate_bytes - OFF_W'(1), 3'b000}) : '0;
   assign state_we_o = !rst && (hs || state_q == CARRY || state_q == PAD);
   assign state_o    = state_we_o ? (inj_result ^ pad_last) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         rate_q        <= '0;
         suffix_q      <= '0;
         off_q         <= '0;
         last_q        <= 1'b0;
         carry_q       <= 1'b0;
         carry_data_q  <= '0;
         carry_keep_q  <= '0;
         s_ready_o     <= 1'b0;
         perm_start_o  <= 1'b0;
         busy_o        <= 1'b0;
         absorb_done_o <= 1'b0;
      end else begin
         perm_start_o  <= 1'b0;
         absorb_done_o <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  rate_q    <= rate_i;
                  suffix_q  <= suffix_i;
                  off_q     <= '0;
                  last_q    <= 1'b0;
                  carry_q   <= 1'b0;
                  state_q   <= ABSORB;
                  s_ready_o <= 1'b1;
                  busy_o    <= 1'b1;
               end
            end
            ABSORB: begin
               if (hs) begin
                  last_q <= s_last_i;
                  if (sum < rate_ext) begin
                     off_q <= off_q + OFF_W'(beat_n);
                     if (s_last_i) begin
                        state_q   <= PAD;
                        s_ready_o <= 1'b0;
                     end
                  end else begin
                     off_q        <= '0;
                     perm_start_o <= 1'b1;
                     state_q      <= PERMUTE;
                     s_ready_o    <= 1'b0;
                     if (sum != rate_ext) begin
                        carry_q      <= 1'b1;
                        carry_data_q <= s_data_i >> {shift_sat, 3'b000};
                        carry_keep_q <= s_keep_i >> shift_sat;
                     end
                  end
               end
            end
            PERMUTE: begin
               if (perm_done_i) begin
                  if (carry_q) begin
                     state_q <= CARRY;
                  end else if (last_q) begin
                     state_q <= PAD;
                  end else begin
                     state_q   <= ABSORB;
                     s_ready_o <= 1'b1;
                  end
               end
            end
            CARRY: begin
               off_q   <= OFF_W'(carry_n);
               carry_q <= 1'b0;
               if (last_q) begin
                  state_q <= PAD;
               end else begin
                  state_q   <= ABSORB;
                  s_ready_o <= 1'b1;
               end
            end
            PAD: begin
               perm_start_o <= 1'b1;
               state_q      <= FINAL;
            end
            FINAL: begin
               if (perm_done_i) begin
                  absorb_done_o <= 1'b1;
                  busy_o        <= 1'b0;
                  state_q       <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_keccak_absorb_stream.sv
// tb/tb_keccak_absorb_stream.sv - directed bench for keccak_absorb_stream with a stand-in permutation core
module tb_keccak_absorb_stream;

   logic          clk = 1'b0;
   logic          rst;
   logic          start_i;
   logic [10:0]   rate_i;
   logic [7:0]    suffix_i;
   logic          s_valid_i;
   logic          s_ready_o;
   logic [255:0]  s_data_i;
   logic [31:0]   s_keep_i;
   logic          s_last_i;
   logic [1599:0] state_i;
   logic [1599:0] state_o;
   logic          state_we_o;
   logic          perm_start_o;
   logic          perm_done_i;
   logic          busy_o;
   logic          absorb_done_o;

   int checks = 0;
   int failures = 0;
   int perm_delay = 0;
   int perm_cnt, hs_cnt, hs_in_perm;
   logic [1599:0] st, pre_perm;
   logic [7:0] msg[$];
   logic hs_we;
   logic [1599:0] hs_so;

   keccak_absorb_stream #(.DWIDTH(256), .KEEP_W(32)) dut (
      .clk(clk), .rst(rst), .start_i(start_i), .rate_i(rate_i), .suffix_i(suffix_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_keep_i(s_keep_i),
      .s_last_i(s_last_i), .state_i(state_i), .state_o(state_o), .state_we_o(state_we_o),
      .perm_start_o(perm_start_o), .perm_done_i(perm_done_i), .busy_o(busy_o),
      .absorb_done_o(absorb_done_o)
   );

   always #5 clk = ~clk;

   function automatic logic [1599:0] perm_f(input logic [1599:0] s);
      return {s[1591:0], s[1599:1592]} ^ 1600'h5A;
   endfunction

   function automatic logic [1599:0] model_digest(input int rb, input logic [7:0] sfx);
      logic [1599:0] s;
      int off;
      s = '0;
      off = 0;
      foreach (msg[k]) begin
         s[8*off +: 8] ^= msg[k];
         off++;
         if (off == rb) begin
            s = perm_f(s);
            off = 0;
         end
      end
      s[8*off +: 8] ^= sfx;
      s[8*(rb-1) +: 8] ^= 8'h80;
      return perm_f(s);
   endfunction

   // Environment: external state register and permutation core with programmable latency.
   initial begin
      logic we_s, ps_s, rst_s;
      logic [1599:0] so_s;
      int cnt;
      logic pend;
      st = '0; pre_perm = '0; pend = 1'b0; cnt = 0;
      perm_cnt = 0; hs_cnt = 0; hs_in_perm = 0;
      state_i = '0; perm_done_i = 1'b0;
      forever begin
         @(negedge clk);
         we_s = state_we_o; so_s = state_o; ps_s = perm_start_o; rst_s = rst;
         if (s_valid_i && s_ready_o) begin
            hs_cnt++;
            if (pend) hs_in_perm++;
         end
         @(posedge clk); #1;
         perm_done_i = 1'b0;
         if (rst_s) begin
            st = '0;
            pend = 1'b0;
         end else begin
            if (we_s) st = so_s;
            if (ps_s) begin
               pend = 1'b1;
               perm_cnt++;
               cnt = perm_delay;
            end else if (pend) begin
               if (cnt == 0) begin
                  pre_perm = st;
                  st = perm_f(st);
                  perm_done_i = 1'b1;
                  pend = 1'b0;
               end else begin
                  cnt--;
               end
            end
         end
         state_i = st;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   task automatic chk_st(input string tag, input logic [1599:0] obs, input logic [1599:0] exp);
      checks++;
      assert (obs === exp) else begin
         int first;
         first = -1;
         for (int i = 199; i >= 0; i--) if (obs[8*i +: 8] !== exp[8*i +: 8]) first = i;
         failures++;
         $display("FAIL %s first_bad_byte=%0d observed=%h expected=%h", tag, first,
                  obs[8*first +: 8], exp[8*first +: 8]);
         $error("check %s", tag);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; start_i = 1'b0; s_valid_i = 1'b0; s_last_i = 1'b0;
      s_keep_i = '0; s_data_i = '0;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic start_msg(input int rate_bits, input logic [7:0] sfx);
      rate_i = 11'(rate_bits); suffix_i = sfx; start_i = 1'b1;
      msg.delete();
      @(posedge clk); #1;
      start_i = 1'b0;
   endtask

   task automatic send(input int n, input logic last, input int base);
      logic got;
      s_data_i = '0; s_keep_i = '0;
      for (int j = 0; j < n; j++) begin
         s_data_i[8*j +: 8] = 8'(base + j);
         s_keep_i[j] = 1'b1;
         msg.push_back(8'(base + j));
      end
      s_last_i = last; s_valid_i = 1'b1;
      got = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (s_ready_o) begin
            got = 1'b1;
            break;
         end
      end
      hs_we = state_we_o; hs_so = state_o;
      if (!got) chk("beat_accept_timeout", 64'(got), 64'd1);
      @(posedge clk); #1;
      s_valid_i = 1'b0; s_last_i = 1'b0;
   endtask

   task automatic wait_done();
      logic got;
      got = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (absorb_done_o) begin
            got = 1'b1;
            break;
         end
      end
      chk("absorb_done_seen", 64'(got), 64'd1);
      @(posedge clk); #1;
   endtask

   initial begin
      int p0, hs0, hip0, rdy_hi;
      logic got;
      logic [1599:0] e;
      logic [191:0] cexp;
      logic [63:0] e64;

      rst = 1'b1; start_i = 1'b0; rate_i = '0; suffix_i = '0; s_valid_i = 1'b0;
      s_data_i = '0; s_keep_i = '0; s_last_i = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", 64'(busy_o), 0);
      chk("reset_ready", 64'(s_ready_o), 0);
      chk("reset_perm_start", 64'(perm_start_o), 0);
      chk("reset_we", 64'(state_we_o), 0);
      chk("reset_done", 64'(absorb_done_o), 0);
      chk_st("reset_state_o", state_o, '0);
      @(posedge clk); #1;

      // SHA3-256 empty message
      perm_delay = 2;
      p0 = perm_cnt;
      start_msg(1088, 8'h06);
      send(0, 1'b1, 0);
      chk("empty_we", 64'(hs_we), 1);
      chk_st("empty_hs_state", hs_so, '0);
      wait_done();
      e = '0; e[7:0] = 8'h06; e[1087:1080] = 8'h80;
      chk_st("empty_padded_block", pre_perm, e);
      chk("empty_perm_count", 64'(perm_cnt - p0), 1);
      @(negedge clk);
      chk("empty_idle_busy", 64'(busy_o), 0);
      @(posedge clk); #1;

      // Straddle at rate 1088 with 32-byte beats
      do_reset();
      perm_delay = 3;
      p0 = perm_cnt;
      start_msg(1088, 8'h06);
      for (int k = 0; k < 4; k++) send(32, 1'b0, 32*k);
      send(32, 1'b0, 128);
      chk("straddle_we", 64'(hs_we), 1);
      for (int j = 0; j < 8; j++) e64[8*j +: 8] = 8'(128 + j);
      chk("straddle_tail_bytes", hs_so[1087:1024], e64);
      chk("straddle_clip", 64'(|hs_so[1599:1088]), 0);
      @(negedge clk);
      chk("straddle_perm_start", 64'(perm_start_o), 1);
      got = 1'b0; rdy_hi = 0;
      for (int c = 0; c < 100; c++) begin
         if (s_ready_o) rdy_hi++;
         if (perm_done_i) begin
            got = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("straddle_perm_done_seen", 64'(got), 1);
      chk("straddle_ready_low_in_perm", 64'(rdy_hi), 0);
      @(negedge clk);
      for (int j = 0; j < 24; j++) cexp[8*j +: 8] = 8'(136 + j);
      chk("carry_ready_low", 64'(s_ready_o), 0);
      chk("carry_we", 64'(state_we_o), 1);
      chk_st("carry_bytes", 1600'(state_o[191:0]), 1600'(state_i[191:0] ^ cexp));
      chk_st("carry_rest", 1600'(state_o[1599:192]), 1600'(state_i[1599:192]));
      @(negedge clk);
      chk("carry_ready_back", 64'(s_ready_o), 1);
      @(posedge clk); #1;
      send(0, 1'b1, 0);
      wait_done();
      chk_st("straddle_digest", st, model_digest(136, 8'h06));
      chk("straddle_perm_count", 64'(perm_cnt - p0), 2);

      // Exact fill then last
      do_reset();
      p0 = perm_cnt;
      start_msg(1088, 8'h06);
      for (int k = 0; k < 4; k++) send(32, 1'b0, 32*k + 7);
      send(8, 1'b1, 135);
      wait_done();
      e = '0;
      for (int i = 0; i < 136; i++) e[8*i +: 8] = msg[i];
      e = perm_f(e);
      e[7:0] ^= 8'h06; e[1087:1080] ^= 8'h80;
      chk_st("exact_second_block", pre_perm, e);
      chk("exact_perm_count", 64'(perm_cnt - p0), 2);
      chk_st("exact_digest", st, model_digest(136, 8'h06));

      // Overlapping pad, SHA3 then SHAKE suffix
      do_reset();
      start_msg(1088, 8'h06);
      for (int k = 0; k < 4; k++) send(32, 1'b0, 32*k);
      send(7, 1'b1, 128);
      wait_done();
      chk("overlap_sha3_byte135", 64'(pre_perm[1087:1080]), 64'h86);
      chk_st("overlap_sha3_digest", st, model_digest(136, 8'h06));
      do_reset();
      start_msg(1088, 8'h1F);
      for (int k = 0; k < 4; k++) send(32, 1'b0, 32*k);
      send(7, 1'b1, 128);
      wait_done();
      chk("overlap_shake_byte135", 64'(pre_perm[1087:1080]), 64'h9F);

      // Back-pressure: slow permutation with valid held high, rate 576
      do_reset();
      perm_delay = 24;
      p0 = perm_cnt; hs0 = hs_cnt; hip0 = hs_in_perm;
      start_msg(576, 8'h1F);
      for (int k = 0; k < 5; k++) send(32, 1'b0, 32*k + 3);
      send(4, 1'b1, 200);
      wait_done();
      chk("bp_beats_taken", 64'(hs_cnt - hs0), 6);
      chk("bp_beats_in_perm", 64'(hs_in_perm - hip0), 0);
      chk("bp_perm_count", 64'(perm_cnt - p0), 3);
      chk_st("bp_digest", st, model_digest(72, 8'h1F));

      // Reset while PERMUTE is pending
      do_reset();
      perm_delay = 10;
      start_msg(1088, 8'h06);
      for (int k = 0; k < 5; k++) send(32, 1'b0, 32*k);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rstp_busy", 64'(busy_o), 0);
      chk("rstp_ready", 64'(s_ready_o), 0);
      chk("rstp_perm_start", 64'(perm_start_o), 0);
      chk("rstp_we", 64'(state_we_o), 0);
      chk("rstp_done", 64'(absorb_done_o), 0);
      chk_st("rstp_state_o", state_o, '0);
      @(posedge clk); #1;
      perm_delay = 1;
      p0 = perm_cnt;
      start_msg(1088, 8'h06);
      send(3, 1'b1, 64);
      wait_done();
      chk("rstp_fresh_perm_count", 64'(perm_cnt - p0), 1);
      chk_st("rstp_fresh_digest", st, model_digest(136, 8'h06));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
